// File: rtl/fmlt_wb_buffer.sv
// rtl/fmlt_wb_buffer.sv - multiply-unit result write-back FIFO with skid stall, overflow flag and flush
module fmlt_wb_buffer #(
    parameter int DEPTH       = 4,
    parameter int WIDTH_DATA  = 32,
    parameter int WIDTH_INDEX = 8,
    parameter int WIDTH_ISSUE = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   I_Valid,
    input  logic [WIDTH_DATA-1:0]  I_Data,
    input  logic [WIDTH_INDEX-1:0] I_Index,
    input  logic [WIDTH_ISSUE-1:0] I_Issue_No,
    input  logic                   I_Flush,
    input  logic                   I_WB_Ready,
    output logic                   O_Stall,
    output logic                   O_WE,
    output logic [WIDTH_INDEX-1:0] O_WAddr,
    output logic [WIDTH_DATA-1:0]  O_WData,
    output logic                   O_Commit,
    output logic [WIDTH_ISSUE-1:0] O_Commit_No,
    output logic                   O_Overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] SKID_C  = CW'(DEPTH - 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           push, pop, we;

    logic [WIDTH_DATA-1:0]  data_mem [DEPTH];
    logic [WIDTH_INDEX-1:0] idx_mem  [DEPTH];
    logic [WIDTH_ISSUE-1:0] iss_mem  [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr_q] <= I_Data;
            idx_mem[wr_ptr_q]  <= I_Index;
            iss_mem[wr_ptr_q]  <= I_Issue_No;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
        pop      = 1'b0;
        case (state_q)
            RUN: begin
                pop  = (count_q != '0) && I_WB_Ready;
                push = I_Valid && ((count_q != FULL_C) || pop);
                if (I_Valid && !push) begin
                    ovf_d = 1'b1;
                end
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
                if (I_Flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign we          = (state_q == RUN) && (count_q != '0);
    assign O_WE        = we;
    assign O_Commit    = pop;
    assign O_WAddr     = we ? idx_mem[rd_ptr_q]  : '0;
    assign O_WData     = we ? data_mem[rd_ptr_q] : '0;
    assign O_Commit_No = we ? iss_mem[rd_ptr_q]  : '0;
    // One free slot is kept as skid for a result already in flight.
    assign O_Stall     = (count_q >= SKID_C) || (state_q == FLUSH);
    assign O_Overflow  = ovf_q;

endmodule

// File: tb/tb_fmlt_wb_buffer.sv
// tb/tb_fmlt_wb_buffer.sv - table-driven bench for fmlt_wb_buffer
module tb_fmlt_wb_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        I_Valid = 1'b0;
    logic [31:0] I_Data = '0;
    logic [7:0]  I_Index = '0;
    logic [5:0]  I_Issue_No = '0;
    logic        I_Flush = 1'b0;
    logic        I_WB_Ready = 1'b0;
    logic        O_Stall, O_WE, O_Commit, O_Overflow;
    logic [7:0]  O_WAddr;
    logic [31:0] O_WData;
    logic [5:0]  O_Commit_No;

    int n_checks = 0;
    int n_pass   = 0;

    fmlt_wb_buffer #(.DEPTH(4), .WIDTH_DATA(32), .WIDTH_INDEX(8), .WIDTH_ISSUE(6)) dut (
        .clock(clock), .reset(reset),
        .I_Valid(I_Valid), .I_Data(I_Data), .I_Index(I_Index), .I_Issue_No(I_Issue_No),
        .I_Flush(I_Flush), .I_WB_Ready(I_WB_Ready),
        .O_Stall(O_Stall), .O_WE(O_WE), .O_WAddr(O_WAddr), .O_WData(O_WData),
        .O_Commit(O_Commit), .O_Commit_No(O_Commit_No), .O_Overflow(O_Overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic [7:0]  idx;
        logic [5:0]  iss;
        logic        flush;
        logic        rdy;
        logic        e_stall;
        logic        e_we;
        logic [7:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_commit;
        logic [5:0]  e_cno;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dat_of(input logic [5:0] iss);
        return 32'hA000_0000 + 32'(iss);
    endfunction

    function automatic logic [7:0] idx_of(input logic [5:0] iss);
        return 8'h10 + 8'(iss);
    endfunction

    // head = issue number expected at the FIFO head when e_we=1
    function automatic vec_t mk(input logic valid, input logic [5:0] iss, input logic flush,
                                input logic rdy, input logic e_stall, input logic e_we,
                                input logic [5:0] head, input logic e_commit, input logic e_ovf);
        vec_t v;
        v.valid    = valid;
        v.iss      = iss;
        v.data     = dat_of(iss);
        v.idx      = idx_of(iss);
        v.flush    = flush;
        v.rdy      = rdy;
        v.e_stall  = e_stall;
        v.e_we     = e_we;
        v.e_waddr  = e_we ? idx_of(head) : 8'h0;
        v.e_wdata  = e_we ? dat_of(head) : 32'h0;
        v.e_commit = e_commit;
        v.e_cno    = e_we ? head : 6'h0;
        v.e_ovf    = e_ovf;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic stall, input logic we,
                         input logic [7:0] waddr, input logic [31:0] wdata, input logic commit,
                         input logic [5:0] cno, input logic ovf);
        n_checks++;
        if ({O_Stall, O_WE, O_WAddr, O_WData, O_Commit, O_Commit_No, O_Overflow} ===
            {stall, we, waddr, wdata, commit, cno, ovf}) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got stall=%b we=%b waddr=%h wdata=%h commit=%b cno=%0d ovf=%b, required stall=%b we=%b waddr=%h wdata=%h commit=%b cno=%0d ovf=%b",
                     name, row, O_Stall, O_WE, O_WAddr, O_WData, O_Commit, O_Commit_No, O_Overflow,
                     stall, we, waddr, wdata, commit, cno, ovf);
        end
    endtask

    task automatic drive(input logic valid, input logic [5:0] iss, input logic flush, input logic rdy);
        @(negedge clock);
        I_Valid    = valid;
        I_Issue_No = iss;
        I_Data     = dat_of(iss);
        I_Index    = idx_of(iss);
        I_Flush    = flush;
        I_WB_Ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        I_Valid = 1'b0;
        I_Flush = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        vec_t v;
        // Single result, custom payload
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        v = mk(1, 3, 0, 1, 0, 0, 0, 0, 0);
        v.data = 32'h3F80_0000; v.idx = 8'd5;
        vecs.push_back(v);
        v = mk(0, 0, 0, 1, 0, 1, 3, 1, 0);
        v.e_waddr = 8'd5; v.e_wdata = 32'h3F80_0000;
        vecs.push_back(v);
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Fill with backpressure
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 4, 0, 0, 1, 1, 1, 0, 0));
        // Full: concurrent push and pop keeps count 4, no overflow
        vecs.push_back(mk(1, 5, 0, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 0, 0));
        // Full, no pop: dropped, sticky overflow
        vecs.push_back(mk(1, 6, 0, 0, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 3, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 4, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 5, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
        // Flush with count 3; flush held into FLUSH is ignored
        vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8, 0, 0, 0, 1, 7, 0, 1));
        vecs.push_back(mk(1, 9, 0, 0, 0, 1, 7, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 7, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 10, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));

        // Outputs while reset is held
        #1;
        check("reset_hold", 0, 0, 0, 8'h0, 32'h0, 0, 6'h0, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clock);
            I_Valid    = v.valid;
            I_Data     = v.data;
            I_Index    = v.idx;
            I_Issue_No = v.iss;
            I_Flush    = v.flush;
            I_WB_Ready = v.rdy;
            #1;
            check("vec", i, v.e_stall, v.e_we, v.e_waddr, v.e_wdata, v.e_commit, v.e_cno, v.e_ovf);
        end

        // Pointer wrap-around: 10 back-to-back results, never stalled
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            drive(k < 10, 6'(20 + k), 0, 1);
            if (k == 0)
                check("wrap", k, 0, 0, 8'h0, 32'h0, 0, 6'h0, 0);
            else
                check("wrap", k, 0, 1, idx_of(6'(19 + k)), dat_of(6'(19 + k)), 1, 6'(19 + k), 0);
        end
        drive(0, 0, 0, 1);
        check("wrap_idle", 0, 0, 0, 8'h0, 32'h0, 0, 6'h0, 0);

        // Asynchronous reset mid-operation with 3 entries buffered
        drive(1, 30, 0, 0);
        drive(1, 31, 0, 0);
        drive(1, 32, 0, 0);
        drive(0, 0, 0, 0);
        check("pre_rst", 0, 1, 1, idx_of(30), dat_of(30), 0, 6'd30, 0);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst", 0, 0, 0, 8'h0, 32'h0, 0, 6'h0, 0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1);
            check("post_rst", k, 0, 0, 8'h0, 32'h0, 0, 6'h0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, required finish before 50000");
        $fatal(1);
    end
endmodule
